chien_search_par: RTL and testbench

//  Parametrised Chien search engine for the RS decoder (DVB-T RS(204,188), shortened from (255,239), GF(2^8)).

---
 rtl/rs_gf_pkg.sv | 56 +++++
 rtl/chien_cell.sv | 43 ++++
 rtl/chien_search_par.sv | 180 ++++++++++++++++++
 tb/tb_chien_search_par.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rs_gf_pkg.sv
// GF(2^M) constants and constant-operand helpers shared by the RS syndrome, Chien and Forney blocks.
// All functions are meant for elaboration-time constants or constant-coefficient XOR networks.
package rs_gf_pkg;

  localparam int            RS_M    = 8;
  localparam logic [RS_M:0] RS_POLY = 9'h11D;
  localparam int            RS_Q    = (1 << RS_M) - 1;

  typedef logic [RS_M-1:0] gf_t;

  typedef enum logic [1:0] {
    CHIEN_IDLE,
    CHIEN_LOAD,
    CHIEN_RUN,
    CHIEN_FINISH
  } chien_state_e;

  function automatic gf_t gf_xtime(input gf_t a, input logic [RS_M:0] poly = RS_POLY);
    return a[RS_M-1] ? ((a << 1) ^ poly[RS_M-1:0]) : (a << 1);
  endfunction

  // alpha^e for any integer e, negative exponents included
  function automatic gf_t gf_alpha_pow(input int e, input logic [RS_M:0] poly = RS_POLY);
    int  r;
    gf_t v;
    r = e % RS_Q;
    if (r < 0) r += RS_Q;
    v = gf_t'(1);
    for (int i = 0; i < r; i++) v = gf_xtime(v, poly);
    return v;
  endfunction

  function automatic int gf_log(input gf_t a, input logic [RS_M:0] poly = RS_POLY);
    gf_t v;
    v = gf_t'(1);
    for (int i = 0; i < RS_Q; i++) begin
      if (v == a) return i;
      v = gf_xtime(v, poly);
    end
    return 0;
  endfunction

  // c must be an elaboration constant so this collapses to a fixed XOR network
  function automatic gf_t gf_mul_const(input gf_t a, input gf_t c, input logic [RS_M:0] poly = RS_POLY);
    gf_t acc;
    gf_t b;
    acc = '0;
    b   = a;
    for (int i = 0; i < RS_M; i++) begin
      if (c[i]) acc ^= b;
      b = gf_xtime(b, poly);
    end
    return acc;
  endfunction

endpackage

// File: rtl/chien_cell.sv
// One Lambda term sigma_k*alpha^(-k*j): holds reg_k, steps it by alpha^(-k*P) per group and
// presents the P lane offsets alpha^(-k*p) combinationally.
module chien_cell
  import rs_gf_pkg::*;
#(
  parameter int         M    = RS_M,
  parameter int         K    = 1,
  parameter int         P    = 1,
  parameter logic [M:0] POLY = RS_POLY
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic                  step,
  input  logic [M-1:0]          sigma,
  output logic [P-1:0][M-1:0]   term
);

  localparam gf_t STEP_C = gf_alpha_pow(-K * P, POLY);

  logic [M-1:0] reg_q;
  logic [M-1:0] reg_d;

  always_comb begin
    reg_d = reg_q;
    if (load) begin
      reg_d = sigma;
    end else if (step) begin
      reg_d = gf_mul_const(reg_q, STEP_C, POLY);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) reg_q <= '0;
    else       reg_q <= reg_d;
  end

  for (genvar p = 0; p < P; p++) begin : g_lane
    localparam gf_t LANE_C = gf_alpha_pow(-K * p, POLY);
    assign term[p] = gf_mul_const(reg_q, LANE_C, POLY);
  end

endmodule

// File: rtl/chien_search_par.sv
// Chien search over positions 0..N-1, P per cycle; Done at ceil(N/P)+2 cycles after Start.
// CHIEN_ODD_SUM_EN adds the OddSum port: per-root odd-term sum x*Lambda'(x) for Forney.
module chien_search_par
  import rs_gf_pkg::*;
#(
  parameter int         M    = RS_M,
  parameter int         T    = 8,
  parameter int         N    = 204,
  parameter int         P    = 1,
  parameter logic [M:0] POLY = RS_POLY,
  localparam int        LW   = $clog2(T + 1)
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [M*T-1:0]   Sigma,
  input  logic [LW-1:0]    L,
  output logic             Busy,
  output logic             Done,
  output logic [M*T-1:0]   Location,
  output logic [LW-1:0]    LocCount,
  output logic             Fail
`ifdef CHIEN_ODD_SUM_EN
  ,
  output logic [M*T-1:0]   OddSum
`endif
);

  localparam int JW = $clog2(N + P + 1);

  chien_state_e          state_q, state_d;
  logic [JW-1:0]         j0_q, j0_d;
  logic [LW-1:0]         l_q, l_d;
  logic [LW-1:0]         cnt_q, cnt_d;
  logic                  ovf_q, ovf_d;
  logic                  fail_q, fail_d;
  logic [T-1:0][M-1:0]   loc_q, loc_d;
`ifdef CHIEN_ODD_SUM_EN
  logic [T-1:0][M-1:0]   odd_q, odd_d;
`endif

  logic [P-1:0][M-1:0]   term [T];
  logic [P-1:0][M-1:0]   lane_odd;
  logic [P-1:0][M-1:0]   lane_even;
  logic [P-1:0][M-1:0]   lane_sum;
  logic                  cell_load;
  logic                  cell_step;

  // Registers take Sigma directly on the Start cycle, so no separate Sigma capture is needed.
  assign cell_load = (state_q == CHIEN_IDLE) && Start;
  assign cell_step = (state_q == CHIEN_RUN);

  for (genvar k = 1; k <= T; k++) begin : g_cell
    chien_cell #(
      .M    (M),
      .K    (k),
      .P    (P),
      .POLY (POLY)
    ) u_cell (
      .clk   (Clk),
      .reset (Reset),
      .load  (cell_load),
      .step  (cell_step),
      .sigma (Sigma[M*k-1 -: M]),
      .term  (term[k-1])
    );
  end

  always_comb begin
    lane_odd  = '0;
    lane_even = '0;
    lane_sum  = '0;
    for (int p = 0; p < P; p++) begin
      for (int k = 1; k <= T; k++) begin
        if (k % 2 == 1) lane_odd[p]  ^= term[k-1][p];
        else            lane_even[p] ^= term[k-1][p];
      end
      lane_sum[p] = M'(1) ^ lane_odd[p] ^ lane_even[p];
    end
  end

  always_comb begin
    state_d = state_q;
    j0_d    = j0_q;
    l_d     = l_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    fail_d  = fail_q;
    loc_d   = loc_q;
`ifdef CHIEN_ODD_SUM_EN
    odd_d   = odd_q;
`endif
    case (state_q)
      CHIEN_IDLE: begin
        if (Start) begin
          state_d = CHIEN_LOAD;
          l_d     = L;
        end
      end
      CHIEN_LOAD: begin
        state_d = CHIEN_RUN;
        j0_d    = '0;
        cnt_d   = '0;
        ovf_d   = 1'b0;
        fail_d  = 1'b0;
        loc_d   = '1;
`ifdef CHIEN_ODD_SUM_EN
        odd_d   = '0;
`endif
      end
      CHIEN_RUN: begin
        // Ascending lane order keeps slots sorted by position within a group.
        for (int p = 0; p < P; p++) begin
          if ((int'(j0_q) + p) < N && lane_sum[p] == '0) begin
            if (int'(cnt_d) < T) begin
              for (int i = 0; i < T; i++) begin
                if (LW'(i) == cnt_d) begin
                  loc_d[i] = M'(int'(j0_q) + p);
`ifdef CHIEN_ODD_SUM_EN
                  odd_d[i] = lane_odd[p];
`endif
                end
              end
              cnt_d = cnt_d + LW'(1);
            end else begin
              ovf_d = 1'b1;
            end
          end
        end
        j0_d = j0_q + JW'(P);
        if (int'(j0_q) + P >= N) begin
          state_d = CHIEN_FINISH;
          fail_d  = (cnt_d != l_q) || ovf_d;
        end
      end
      CHIEN_FINISH: begin
        state_d = CHIEN_IDLE;
      end
      default: begin
        state_d = CHIEN_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= CHIEN_IDLE;
      j0_q    <= '0;
      l_q     <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      fail_q  <= 1'b0;
      loc_q   <= '1;
`ifdef CHIEN_ODD_SUM_EN
      odd_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      j0_q    <= j0_d;
      l_q     <= l_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      fail_q  <= fail_d;
      loc_q   <= loc_d;
`ifdef CHIEN_ODD_SUM_EN
      odd_q   <= odd_d;
`endif
    end
  end

  assign Busy     = (state_q != CHIEN_IDLE);
  assign Done     = (state_q == CHIEN_FINISH);
  assign Location = loc_q;
  assign LocCount = cnt_q;
  assign Fail     = fail_q;
`ifdef CHIEN_ODD_SUM_EN
  assign OddSum   = odd_q;
`endif

endmodule

// File: tb/tb_chien_search_par.sv
// Runs five instances (P = 1, 2, 4, 8, 12) in lockstep against a brute-force Lambda evaluator.
module tb_chien_search_par;

  localparam int NP = 5;
  localparam int T  = 8;
  localparam int N  = 204;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        start;
  logic [63:0] sigma;
  logic [3:0]  l_in;

  logic        busy_w [NP];
  logic        done_w [NP];
  logic        fail_w [NP];
  logic [63:0] loc_w  [NP];
  logic [3:0]  cnt_w  [NP];
`ifdef CHIEN_ODD_SUM_EN
  logic [63:0] odd_w  [NP];
`endif

  int checks   = 0;
  int failures = 0;

  logic [7:0] exp_t [255];
  int         log_t [256];

  function automatic int pval(input int g);
    case (g)
      0: return 1;
      1: return 2;
      2: return 4;
      3: return 8;
      default: return 12;
    endcase
  endfunction

  for (genvar g = 0; g < NP; g++) begin : g_dut
    chien_search_par #(.P(pval(g))) u_dut (
      .Clk      (clk),
      .Reset    (reset),
      .Start    (start),
      .Sigma    (sigma),
      .L        (l_in),
      .Busy     (busy_w[g]),
      .Done     (done_w[g]),
      .Location (loc_w[g]),
      .LocCount (cnt_w[g]),
      .Fail     (fail_w[g])
`ifdef CHIEN_ODD_SUM_EN
      ,
      .OddSum   (odd_w[g])
`endif
    );
  end

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    if (a == 8'h00 || b == 8'h00) return 8'h00;
    return exp_t[(log_t[a] + log_t[b]) % 255];
  endfunction

  // Direct evaluation of Lambda(alpha^-j) for every position, roots collected in position order
  task automatic model(input logic [63:0] sg, output logic [63:0] eloc, output logic [63:0] eodd,
                       output logic [3:0] ecnt, output logic eovf);
    int n;
    n    = 0;
    eloc = '1;
    eodd = '0;
    eovf = 1'b0;
    for (int j = 0; j < N; j++) begin
      logic [7:0] x, xp, s, od, t;
      x  = exp_t[(255 - j) % 255];
      xp = 8'h01;
      s  = 8'h01;
      od = 8'h00;
      for (int k = 1; k <= T; k++) begin
        xp = gmul(xp, x);
        t  = gmul(sg[8*k-1 -: 8], xp);
        s ^= t;
        if (k % 2 == 1) od ^= t;
      end
      if (s == 8'h00) begin
        if (n < T) begin
          eloc[8*n +: 8] = 8'(j);
          eodd[8*n +: 8] = od;
          n++;
        end else begin
          eovf = 1'b1;
        end
      end
    end
    ecnt = 4'(n);
  endtask

  task automatic chk(input string nm, input int g, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s P=%0d actual=%h expected=%h", nm, pval(g), act, expv);
    end
  endtask

  task automatic run_and_check(input logic [63:0] sg, input logic [3:0] lv, input logic [63:0] eloc,
                               input logic [3:0] ecnt, input logic efail, input int spur);
    int          done_cyc  [NP];
    int          done_n    [NP];
    logic        busy_after[NP];
    logic [63:0] mloc, modd;
    logic [3:0]  mcnt;
    logic        movf;
    model(sg, mloc, modd, mcnt, movf);
    for (int g = 0; g < NP; g++) begin
      done_cyc[g]   = -1;
      done_n[g]     = 0;
      busy_after[g] = 1'b1;
    end
    @(negedge clk);
    sigma = sg;
    l_in  = lv;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    sigma = {$urandom, $urandom};
    l_in  = 4'($urandom_range(0, 8));
    for (int k = 1; k <= 230; k++) begin
      start = (k == spur);
      if (k == spur) sigma = ~sg;
      for (int g = 0; g < NP; g++) begin
        if (done_w[g]) begin
          if (done_n[g] == 0) done_cyc[g] = k;
          done_n[g]++;
        end
        if (k == (N + pval(g) - 1) / pval(g) + 3) busy_after[g] = busy_w[g];
      end
      @(negedge clk);
    end
    start = 1'b0;
    for (int g = 0; g < NP; g++) begin
      chk("done_cycle", g, 64'(done_cyc[g]), 64'((N + pval(g) - 1) / pval(g) + 2));
      chk("done_pulses", g, 64'(done_n[g]), 64'd1);
      chk("busy_after_done", g, 64'(busy_after[g]), 64'd0);
      chk("location", g, loc_w[g], eloc);
      chk("loc_count", g, 64'(cnt_w[g]), 64'(ecnt));
      chk("fail", g, 64'(fail_w[g]), 64'(efail));
`ifdef CHIEN_ODD_SUM_EN
      for (int i = 0; i < int'(ecnt); i++) chk("odd_sum", g, 64'(odd_w[g][8*i +: 8]), 64'(modd[8*i +: 8]));
`endif
    end
  endtask

  typedef struct {
    logic [63:0] sg;
    logic [3:0]  lv;
    logic [63:0] eloc;
    logic [3:0]  ecnt;
    logic        efail;
    int          spur;
  } vec_t;

  vec_t tbl [5];

  initial begin
    logic [7:0]  v;
    logic [7:0]  c [9];
    logic        used [255];
    logic [63:0] sg, mloc, modd;
    logic [3:0]  mcnt, lv;
    logic        movf;
    int          e, nr, j;
    int          ndone [NP];

    v = 8'h01;
    log_t[0] = 0;
    for (int i = 0; i < 255; i++) begin
      exp_t[i] = v;
      log_t[v] = i;
      v = v[7] ? ((v << 1) ^ 8'h1D) : (v << 1);
    end

    reset = 1'b1;
    start = 1'b0;
    sigma = '0;
    l_in  = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    for (int g = 0; g < NP; g++) begin
      chk("reset_busy", g, 64'(busy_w[g]), 64'd0);
      chk("reset_done", g, 64'(done_w[g]), 64'd0);
      chk("reset_location", g, loc_w[g], '1);
      chk("reset_count", g, 64'(cnt_w[g]), 64'd0);
      chk("reset_fail", g, 64'(fail_w[g]), 64'd0);
    end

    tbl[0] = '{64'h20,               4'd1, 64'hFFFF_FFFF_FFFF_FF05, 4'd1, 1'b0, 5};
    tbl[1] = '{64'h0203,             4'd2, 64'hFFFF_FFFF_FFFF_0100, 4'd2, 1'b0, 0};
    tbl[2] = '{64'h20,               4'd2, 64'hFFFF_FFFF_FFFF_FF05, 4'd1, 1'b1, 0};
    tbl[3] = '{{56'h0, exp_t[250]},  4'd1, 64'hFFFF_FFFF_FFFF_FFFF, 4'd0, 1'b1, 0};
    tbl[4] = '{64'h0,                4'd0, 64'hFFFF_FFFF_FFFF_FFFF, 4'd0, 1'b0, 0};
    for (int i = 0; i < 5; i++) begin
      run_and_check(tbl[i].sg, tbl[i].lv, tbl[i].eloc, tbl[i].ecnt, tbl[i].efail, tbl[i].spur);
    end

    for (int t = 0; t < 12; t++) begin
      if (t < 9) begin
        // Lambda built from chosen error positions; odd trials allow positions past N
        for (int i = 0; i < 255; i++) used[i] = 1'b0;
        for (int i = 0; i < 9; i++) c[i] = 8'h00;
        c[0] = 8'h01;
        e  = (t < 5) ? 8 : int'($urandom_range(1, 8));
        nr = 0;
        while (nr < e) begin
          j = (t % 2 == 1) ? int'($urandom_range(0, 254)) : int'($urandom_range(0, N - 1));
          if (!used[j]) begin
            used[j] = 1'b1;
            for (int k = nr + 1; k >= 1; k--) c[k] ^= gmul(c[k-1], exp_t[j]);
            nr++;
          end
        end
        sg = '0;
        for (int k = 1; k <= T; k++) sg[8*k-1 -: 8] = c[k];
        lv = 4'(e);
      end else begin
        sg = {$urandom, $urandom};
        lv = 4'($urandom_range(0, 8));
      end
      model(sg, mloc, modd, mcnt, movf);
      run_and_check(sg, lv, mloc, mcnt, (mcnt != lv) || movf, 0);
    end

    @(negedge clk);
    sigma = 64'h20;
    l_in  = 4'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    for (int g = 0; g < NP; g++) chk("busy_before_reset", g, 64'(busy_w[g]), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int g = 0; g < NP; g++) begin
      chk("abort_busy", g, 64'(busy_w[g]), 64'd0);
      chk("abort_location", g, loc_w[g], '1);
      chk("abort_count", g, 64'(cnt_w[g]), 64'd0);
      ndone[g] = 0;
    end
    for (int k = 0; k < 230; k++) begin
      for (int g = 0; g < NP; g++) if (done_w[g]) ndone[g]++;
      @(negedge clk);
    end
    for (int g = 0; g < NP; g++) chk("abort_no_done", g, 64'(ndone[g]), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
